reg_bank_csr: RTL and testbench
===============================

Name: reg_bank_csr

Overview:
Parametrised bank of P_NUM_REGS control/status registers, each P_WIDTH bits, behind a simple memory-mapped slave port with byte enables and registered read data. Each register slot has a compile-time access mode: read/write, read-only hardware status, sticky write-1-to-clear event, or write-1 self-clearing pulse. It is the bank-level successor to the single RW register, used by the sequencer CSR block to replace hand-instantiated register arrays.

Parameters:
P_WIDTH, 32, bits per register; must be a multiple of 8.
P_NUM_REGS, 8, number of register slots; range 1..256.
P_ADDR_W, 3, word-address width; must satisfy 2**P_ADDR_W >= P_NUM_REGS.
P_MODE, all zeros, flat 2*P_NUM_REGS vector; bits [2i+1:2i] set slot i mode: 0 = RW, 1 = RO, 2 = W1C, 3 = PULSE.

Ports:
CLOCK  input  1  bank clock
RESET_N  input  1  asynchronous active-low reset
INIT  input  P_NUM_REGS*P_WIDTH  reset value per slot; slot i is [i*P_WIDTH +: P_WIDTH]
ADDRESS  input  P_ADDR_W  word address for the current access
WRITE  input  1  write strobe, single cycle, no wait states
READ  input  1  read strobe, single cycle
WRITEDATA  input  P_WIDTH  write data
BYTEENABLE  input  P_WIDTH/8  per-byte write qualifier
READDATA  output  P_WIDTH  registered read data
READDATAVALID  output  1  high for one cycle, one cycle after READ
HW_IN  input  P_NUM_REGS*P_WIDTH  RO slots: status value; W1C slots: per-bit set pulses; ignored for RW and PULSE
REG_Q  output  P_NUM_REGS*P_WIDTH  current register contents to the fabric

Behaviour:
- Clocking and reset: one clock, CLOCK. Reset is asynchronous, active-low on RESET_N.
- On reset: every slot is loaded from INIT, including PULSE slots. READDATA = 0. READDATAVALID = 0. Reset asserted mid-access aborts the access; no READDATAVALID follows.
- Write decode: a write hits slot i when WRITE=1 and ADDRESS==i. Bit b is enabled when BYTEENABLE[b/8]=1.
- RW mode: each enabled bit loads WRITEDATA[b] on the clock edge. Disabled bits hold.
- RO mode: the slot register samples HW_IN every cycle, so REG_Q follows HW_IN with 1-cycle latency. Writes are ignored.
- W1C mode: bit sets when its HW_IN bit is 1. An enabled write bit of 1 clears it. Write 0 has no effect. If set and clear occur in the same cycle, set wins (bit = 1).
- PULSE mode: an enabled write bit of 1 sets the bit for exactly one cycle; the next cycle it returns to 0 unless written again. Back-to-back writes keep it high. Reads return the current register value.
- Read: READ=1 at cycle N gives READDATA = slot value as it stood before any same-cycle write, with READDATAVALID=1 at N+1. Otherwise READDATAVALID=0 and READDATA holds its last value.
- Same-cycle READ and WRITE to the same slot is legal: read returns the old value, write takes effect.
- Out-of-range address (ADDRESS >= P_NUM_REGS): writes are ignored; reads return 0 with READDATAVALID still asserted.
- READ and WRITE may be asserted every cycle; throughput is one access per cycle.
- Illegal parameter combinations (width not a multiple of 8, address too narrow) must fail elaboration via a generate-time check.

Optional Feature:
Macro REG_BANK_CSR_IRQ_EN.
- Defined:
  - Adds output IRQ (1 bit) and an internal per-slot IRQ mask, P_WIDTH bits for each W1C slot.
  - The mask is written at address P_NUM_REGS + i for W1C slot i, using RW semantics with byte enables, and is readable at the same address.
  - The mask resets to all zeros.
  - IRQ is registered: it goes high 1 cycle after any (W1C bit AND mask bit) is set, and drops 1 cycle after all such bits clear.
  - Mask addresses are excluded from the out-of-range rule.
- Undefined: no IRQ port and no mask storage. Addresses >= P_NUM_REGS are out-of-range as above.

Test Plan:
- Reset with INIT slot0=0xA5A5_A5A5, then read address 0 -> READDATA=0xA5A5_A5A5 with READDATAVALID one cycle after READ; all other outputs at reset values.
- RW slot 1 = 0, write 0xDEADBEEF with BYTEENABLE=4'b0101 -> slot reads 0x00AD00EF; REG_Q slot 1 matches.
- W1C slot 2: pulse HW_IN bit 3 -> reads 0x8. Write 0x8 while HW_IN bit 3 is high in the same cycle -> still 0x8. Write 0x8 on the next cycle with HW_IN low -> 0x0.
- PULSE slot 3: write 0x1 -> REG_Q bit0 high for exactly 1 cycle. Two consecutive writes -> high for exactly 2 cycles.
- RO slot 4: drive HW_IN=0x1234 and write 0xFFFF -> read returns 0x1234. Read to address 7 with P_NUM_REGS=5 -> READDATA=0, READDATAVALID=1. Same-cycle read and write 0x55 to RW slot 0 holding 0x11 -> read returns 0x11, next read 0x55.
- With REG_BANK_CSR_IRQ_EN defined: set mask bit 3 of slot 2, pulse HW_IN bit 3 -> IRQ high 1 cycle later. Write-clear -> IRQ low 1 cycle after the bit clears. Assert reset mid-sequence -> IRQ=0 and mask=0.

Source files
------------

// File: rtl/reg_bank_csr.sv
// reg_bank_csr: parametrised bank of control/status registers behind a simple
// memory-mapped slave port with byte enables and registered read data.
// Per-slot access mode comes from P_MODE: 0 = RW, 1 = RO, 2 = W1C, 3 = PULSE.
// Optional feature macro REG_BANK_CSR_IRQ_EN: adds a per-W1C-slot interrupt
// mask at address P_NUM_REGS + i and a registered IRQ output.
module reg_bank_csr #(
  parameter int unsigned               P_WIDTH    = 32,
  parameter int unsigned               P_NUM_REGS = 8,
  parameter int unsigned               P_ADDR_W   = 3,
  parameter logic [2*P_NUM_REGS-1:0]   P_MODE     = '0
) (
  input  logic                            CLOCK,
  input  logic                            RESET_N,
  input  logic [P_NUM_REGS*P_WIDTH-1:0]   INIT,
  input  logic [P_ADDR_W-1:0]             ADDRESS,
  input  logic                            WRITE,
  input  logic                            READ,
  input  logic [P_WIDTH-1:0]              WRITEDATA,
  input  logic [P_WIDTH/8-1:0]            BYTEENABLE,
  output logic [P_WIDTH-1:0]              READDATA,
  output logic                            READDATAVALID,
  input  logic [P_NUM_REGS*P_WIDTH-1:0]   HW_IN,
  output logic [P_NUM_REGS*P_WIDTH-1:0]   REG_Q
`ifdef REG_BANK_CSR_IRQ_EN
  ,
  output logic                            IRQ
`endif
);

  localparam logic [1:0] MODE_RW    = 2'd0;
  localparam logic [1:0] MODE_RO    = 2'd1;
  localparam logic [1:0] MODE_W1C   = 2'd2;

  // Parameter legality checks, resolved at elaboration
  if (P_WIDTH == 0 || (P_WIDTH % 8) != 0) begin : g_bad_width
    $error("reg_bank_csr: P_WIDTH must be a non-zero multiple of 8");
  end
  if (P_NUM_REGS < 1 || P_NUM_REGS > 256) begin : g_bad_num
    $error("reg_bank_csr: P_NUM_REGS must be in 1..256");
  end
  if ((64'(1) << P_ADDR_W) < 64'(P_NUM_REGS)) begin : g_bad_addr
    $error("reg_bank_csr: P_ADDR_W too narrow for P_NUM_REGS");
  end

  logic [31:0]             addr_u;
  logic [P_WIDTH-1:0]      be_bits;
  logic [P_WIDTH-1:0]      wr_bits;
  logic [P_NUM_REGS-1:0]   wr_hit;
  logic [P_WIDTH-1:0]      slot_v [P_NUM_REGS];
  logic [P_WIDTH-1:0]      rd_mux;

  // Address compared as a wide unsigned value so mask addresses never alias
  assign addr_u  = 32'(ADDRESS);
  assign wr_bits = WRITEDATA & be_bits;

  // Expand byte enables to a per-bit write qualifier
  always_comb begin
    be_bits = '0;
    for (int b = 0; b < int'(P_WIDTH); b++) begin
      be_bits[b] = BYTEENABLE[b/8];
    end
  end

  // Per-slot write decode
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < int'(P_NUM_REGS); i++) begin
      wr_hit[i] = WRITE && (addr_u == 32'(i));
    end
  end

`ifdef REG_BANK_CSR_IRQ_EN
  logic [P_WIDTH-1:0] mask_v [P_NUM_REGS];
  logic               irq_c;
`endif

  for (genvar i = 0; i < int'(P_NUM_REGS); i++) begin : g_slot
    localparam logic [1:0] LP_MODE = P_MODE[2*i +: 2];
    logic [P_WIDTH-1:0] slot_q;
    logic [P_WIDTH-1:0] hw_s;

    assign hw_s = HW_IN[i*P_WIDTH +: P_WIDTH];

    // Slot storage; behaviour selected by the slot's access mode
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        slot_q <= INIT[i*P_WIDTH +: P_WIDTH];
      end else begin
        case (LP_MODE)
          MODE_RW:  if (wr_hit[i]) slot_q <= (slot_q & ~be_bits) | wr_bits;
          MODE_RO:  slot_q <= hw_s;
          MODE_W1C: slot_q <= (slot_q & ~(wr_hit[i] ? wr_bits : '0)) | hw_s;
          default:  slot_q <= wr_hit[i] ? wr_bits : '0;
        endcase
      end
    end

    assign slot_v[i] = slot_q;
    assign REG_Q[i*P_WIDTH +: P_WIDTH] = slot_q;

`ifdef REG_BANK_CSR_IRQ_EN
    if (LP_MODE == MODE_W1C) begin : g_mask
      logic [P_WIDTH-1:0] mask_q;
      logic               mask_hit;

      assign mask_hit = WRITE && (addr_u == 32'(P_NUM_REGS + i));

      // Interrupt mask for this W1C slot, plain RW with byte enables
      always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
          mask_q <= '0;
        end else if (mask_hit) begin
          mask_q <= (mask_q & ~be_bits) | wr_bits;
        end
      end

      assign mask_v[i] = mask_q;
    end else begin : g_nomask
      assign mask_v[i] = '0;
    end
`endif
  end

  // Read mux; anything not decoded reads as zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < int'(P_NUM_REGS); i++) begin
      if (addr_u == 32'(i)) rd_mux = slot_v[i];
`ifdef REG_BANK_CSR_IRQ_EN
      if (addr_u == 32'(P_NUM_REGS + 32'(i))) rd_mux = mask_v[i];
`endif
    end
  end

  // Registered read response; data holds between reads
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      READDATA      <= '0;
      READDATAVALID <= 1'b0;
    end else begin
      READDATAVALID <= READ;
      if (READ) READDATA <= rd_mux;
    end
  end

`ifdef REG_BANK_CSR_IRQ_EN
  // Any masked W1C bit raises the interrupt
  always_comb begin
    irq_c = 1'b0;
    for (int i = 0; i < int'(P_NUM_REGS); i++) begin
      irq_c = irq_c | (|(slot_v[i] & mask_v[i]));
    end
  end

  // Registered interrupt output
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) IRQ <= 1'b0;
    else          IRQ <= irq_c;
  end
`endif

  // HW_IN bits of RW/PULSE slots and decode bits of RO slots are intentionally unused
  logic unused_sink;
  assign unused_sink = ^{HW_IN, wr_hit};

endmodule

// File: tb/tb_reg_bank_csr.sv
// tb_reg_bank_csr: directed plus randomized check of reg_bank_csr against a
// behavioural model of the register bank.
module tb_reg_bank_csr;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 5;
  localparam int unsigned AW = 3;
  // slot0 RW, slot1 RW, slot2 W1C, slot3 PULSE, slot4 RO
  localparam logic [2*N-1:0] MODE = 10'b01_11_10_00_00;

  logic                CLOCK = 1'b0;
  logic                RESET_N = 1'b1;
  logic [N*W-1:0]      INIT;
  logic [AW-1:0]       ADDRESS;
  logic                WRITE;
  logic                READ;
  logic [W-1:0]        WRITEDATA;
  logic [W/8-1:0]      BYTEENABLE;
  logic [W-1:0]        READDATA;
  logic                READDATAVALID;
  logic [N*W-1:0]      HW_IN;
  logic [N*W-1:0]      REG_Q;
`ifdef REG_BANK_CSR_IRQ_EN
  logic                IRQ;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  reg_bank_csr #(
    .P_WIDTH(W), .P_NUM_REGS(N), .P_ADDR_W(AW), .P_MODE(MODE)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .INIT(INIT), .ADDRESS(ADDRESS),
    .WRITE(WRITE), .READ(READ), .WRITEDATA(WRITEDATA), .BYTEENABLE(BYTEENABLE),
    .READDATA(READDATA), .READDATAVALID(READDATAVALID), .HW_IN(HW_IN),
    .REG_Q(REG_Q)
`ifdef REG_BANK_CSR_IRQ_EN
    , .IRQ(IRQ)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_reg  [N];
  logic [W-1:0] m_mask [N];
  logic [W-1:0] m_rdata;
  logic         m_rvalid;
  logic         m_irq;

  function automatic int mode_of(int i);
    logic [2*N-1:0] m;
    m = MODE;
    return int'(m[2*i +: 2]);
  endfunction

  function automatic logic [W-1:0] expand_be(logic [W/8-1:0] be);
    logic [W-1:0] r;
    for (int b = 0; b < int'(W); b++) r[b] = be[b/8];
    return r;
  endfunction

  function automatic logic [W-1:0] read_val();
    int a;
    a = int'(ADDRESS);
    if (a < int'(N)) return m_reg[a];
`ifdef REG_BANK_CSR_IRQ_EN
    if (a < 2*int'(N) && mode_of(a - int'(N)) == 2) return m_mask[a - int'(N)];
`endif
    return '0;
  endfunction

  function automatic logic [W-1:0] next_reg(int i);
    logic [W-1:0] wr, hw;
    bit hit;
    wr  = WRITEDATA & expand_be(BYTEENABLE);
    hw  = HW_IN[i*W +: W];
    hit = WRITE && int'(ADDRESS) == i;
    case (mode_of(i))
      0:       return hit ? ((m_reg[i] & ~expand_be(BYTEENABLE)) | wr) : m_reg[i];
      1:       return hw;
      2:       return (m_reg[i] & ~(hit ? wr : '0)) | hw;
      default: return hit ? wr : '0;
    endcase
  endfunction

  function automatic logic [W-1:0] next_mask(int i);
    bit hit;
    hit = WRITE && int'(ADDRESS) == int'(N) + i && mode_of(i) == 2;
    if (hit) return (m_mask[i] & ~expand_be(BYTEENABLE)) | (WRITEDATA & expand_be(BYTEENABLE));
    return m_mask[i];
  endfunction

  function automatic logic irq_val();
    for (int i = 0; i < int'(N); i++)
      if (mode_of(i) == 2 && (m_reg[i] & m_mask[i]) != '0) return 1'b1;
    return 1'b0;
  endfunction

  // Model state advance, async reset like the bank
  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(N); i++) begin
        m_reg[i]  <= INIT[i*W +: W];
        m_mask[i] <= '0;
      end
      m_rdata  <= '0;
      m_rvalid <= 1'b0;
      m_irq    <= 1'b0;
    end else begin
      m_rvalid <= READ;
      if (READ) m_rdata <= read_val();
      m_irq <= irq_val();
      for (int i = 0; i < int'(N); i++) begin
        m_reg[i]  <= next_reg(i);
        m_mask[i] <= next_mask(i);
      end
    end
  end

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge CLOCK) begin
    if (chk_en) begin
      check("readdatavalid", W'(READDATAVALID), W'(m_rvalid));
      check("readdata", READDATA, m_rdata);
      for (int i = 0; i < int'(N); i++)
        check($sformatf("reg_q[%0d]", i), REG_Q[i*W +: W], m_reg[i]);
`ifdef REG_BANK_CSR_IRQ_EN
      check("irq", W'(IRQ), W'(m_irq));
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [N*W-1:0] hw_slot(int i, logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = v;
    return r;
  endfunction

  task automatic step(bit we, bit re, int addr, logic [W-1:0] wd,
                      logic [W/8-1:0] be, logic [N*W-1:0] hw);
    @(negedge CLOCK);
    WRITE = we; READ = re; ADDRESS = AW'(addr);
    WRITEDATA = wd; BYTEENABLE = be; HW_IN = hw;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, '0, '0);
  endtask

  initial begin
    logic [N*W-1:0] hw_r;
    INIT = '0;
    INIT[0 +: W] = 32'hA5A5_A5A5;
    WRITE = 1'b0; READ = 1'b0; ADDRESS = '0;
    WRITEDATA = '0; BYTEENABLE = '0; HW_IN = '0;
    #1 RESET_N = 1'b0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    #2 RESET_N = 1'b1;
    chk_en = 1'b1;

    // Reset state
    check("rst_readdata", READDATA, 32'h0);
    check("rst_rvalid", W'(READDATAVALID), 32'h0);
    check("rst_slot0", REG_Q[0 +: W], 32'hA5A5_A5A5);

    // Read slot 0
    step(1'b0, 1'b1, 0, '0, '0, '0);
    check("rd0_data", READDATA, 32'hA5A5_A5A5);
    check("rd0_valid", W'(READDATAVALID), 32'h1);
    idle();
    check("rd0_valid_drop", W'(READDATAVALID), 32'h0);
    check("rd0_hold", READDATA, 32'hA5A5_A5A5);

    // RW with partial byte enables
    step(1'b1, 1'b0, 1, 32'hDEAD_BEEF, 4'b0101, '0);
    check("rw_be_regq", REG_Q[1*W +: W], 32'h00AD_00EF);
    step(1'b0, 1'b1, 1, '0, '0, '0);
    check("rw_be_read", READDATA, 32'h00AD_00EF);

    // W1C: set, set-wins-over-clear, clear
    step(1'b0, 1'b0, 0, '0, '0, hw_slot(2, 32'h8));
    check("w1c_set", REG_Q[2*W +: W], 32'h8);
    step(1'b0, 1'b1, 2, '0, '0, '0);
    check("w1c_read", READDATA, 32'h8);
    step(1'b1, 1'b0, 2, 32'h8, 4'hF, hw_slot(2, 32'h8));
    check("w1c_set_wins", REG_Q[2*W +: W], 32'h8);
    step(1'b1, 1'b0, 2, 32'h8, 4'hF, '0);
    check("w1c_clear", REG_Q[2*W +: W], 32'h0);

    // PULSE: one write -> one cycle, two writes -> two cycles
    step(1'b1, 1'b0, 3, 32'h1, 4'hF, '0);
    check("pulse1_hi", REG_Q[3*W +: W], 32'h1);
    idle();
    check("pulse1_lo", REG_Q[3*W +: W], 32'h0);
    step(1'b1, 1'b0, 3, 32'h1, 4'hF, '0);
    step(1'b1, 1'b0, 3, 32'h1, 4'hF, '0);
    check("pulse2_hi", REG_Q[3*W +: W], 32'h1);
    idle();
    check("pulse2_lo", REG_Q[3*W +: W], 32'h0);

    // RO ignores writes, follows HW_IN
    step(1'b1, 1'b0, 4, 32'hFFFF, 4'hF, hw_slot(4, 32'h1234));
    check("ro_regq", REG_Q[4*W +: W], 32'h1234);
    step(1'b0, 1'b1, 4, '0, '0, hw_slot(4, 32'h1234));
    check("ro_read", READDATA, 32'h1234);

    // Out-of-range read (mask address reads as zero mask when IRQ feature present)
    step(1'b0, 1'b1, 7, '0, '0, '0);
    check("oor_data", READDATA, 32'h0);
    check("oor_valid", W'(READDATAVALID), 32'h1);

    // Same-cycle read and write returns old value
    step(1'b1, 1'b0, 0, 32'h11, 4'hF, '0);
    step(1'b1, 1'b1, 0, 32'h55, 4'hF, '0);
    check("rw_same_old", READDATA, 32'h11);
    step(1'b0, 1'b1, 0, '0, '0, '0);
    check("rw_same_new", READDATA, 32'h55);

`ifdef REG_BANK_CSR_IRQ_EN
    // Mask bit 3 of slot 2, raise and clear the event
    step(1'b1, 1'b0, 7, 32'h8, 4'hF, '0);
    step(1'b0, 1'b0, 0, '0, '0, hw_slot(2, 32'h8));
    check("irq_not_yet", W'(IRQ), 32'h0);
    idle();
    check("irq_high", W'(IRQ), 32'h1);
    step(1'b1, 1'b0, 2, 32'h8, 4'hF, '0);
    check("irq_still_high", W'(IRQ), 32'h1);
    idle();
    check("irq_low", W'(IRQ), 32'h0);
    step(1'b0, 1'b0, 0, '0, '0, hw_slot(2, 32'h8));
`endif

    // Reset asserted while a read is pending aborts it
    @(negedge CLOCK);
    WRITE = 1'b0; READ = 1'b1; ADDRESS = '0; HW_IN = '0;
    #2 RESET_N = 1'b0;
    @(posedge CLOCK);
    #1;
    check("abort_valid", W'(READDATAVALID), 32'h0);
    check("abort_slot0", REG_Q[0 +: W], 32'hA5A5_A5A5);
    check("abort_slot1", REG_Q[1*W +: W], 32'h0);
`ifdef REG_BANK_CSR_IRQ_EN
    check("abort_irq", W'(IRQ), 32'h0);
`endif
    @(negedge CLOCK);
    READ = 1'b0;
    #2 RESET_N = 1'b1;
    idle();
    check("post_abort_valid", W'(READDATAVALID), 32'h0);
`ifdef REG_BANK_CSR_IRQ_EN
    step(1'b0, 1'b1, 7, '0, '0, '0);
    check("mask_reset", READDATA, 32'h0);
`endif

    // Randomized traffic, checked every cycle by the compare process
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < int'(N); i++)
        hw_r[i*W +: W] = (i == 4) ? $urandom : ($urandom & $urandom & $urandom);
      step(1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
           $urandom, 4'($urandom), hw_r);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
